rv32i_test_sequencer: RTL and testbench

//  Synthesizable self-check controller for rv32i regression runs.
//  - Holds the core in reset, then runs NUM_TESTS programs back to back.
//  - Each program reports its result by a word store to TOHOST_ADDR (riscv-tests convention).
//  - A cycle watchdog catches hung programs.
//  - Outputs a per-test result strobe, pass/fail counters and a final verdict that benches read

---
 rtl/rv32i_test_sequencer_pkg.sv | 36 +++
 rtl/rv32i_test_sequencer_if.sv | 10 +
 rtl/rv32i_watchdog.sv | 27 ++
 rtl/rv32i_test_sequencer.sv | 145 ++++++++++++++
 tb/tb_rv32i_test_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_test_sequencer_pkg.sv
// Shared types and constants for the rv32i regression sequencer.
// Decodes core stores to the tohost mailbox.
package rv32i_test_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_RESET_CORE,
        SEQ_RUN,
        SEQ_RESULT,
        SEQ_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        HIT_NONE,
        HIT_PASS,
        HIT_FAIL
    } hit_t;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h8000_1000;
    localparam logic [30:0] TIMEOUT_CODE   = 31'h7FFF_FFFF;

    // Stores with wdata[0]==0 are console/syscall traffic, not a verdict.
    function automatic hit_t classify_store(input logic        we,
                                            input logic [31:0] addr,
                                            input logic [3:0]  be,
                                            input logic [31:0] wdata,
                                            input logic [31:0] tohost);
        hit_t h;
        h = HIT_NONE;
        if (we && addr == tohost && be == 4'hF && wdata[0]) begin
            h = (wdata == 32'd1) ? HIT_PASS : HIT_FAIL;
        end
        return h;
    endfunction

endpackage

// File: rtl/rv32i_test_sequencer_if.sv
// Core data-memory store bus observed by the test sequencer.
interface rv32i_test_sequencer_if;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;

    modport master (output dmem_we, dmem_addr, dmem_be, dmem_wdata);
    modport slave  (input  dmem_we, dmem_addr, dmem_be, dmem_wdata);
endinterface

// File: rtl/rv32i_watchdog.sv
// 32-bit saturating cycle counter with synchronous clear/enable.
// Flags expiry when the count reaches LIMIT-1.
module rv32i_watchdog #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [31:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && cnt != 32'hFFFF_FFFF) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign expired = (cnt == 32'(LIMIT - 1));

endmodule

// File: rtl/rv32i_test_sequencer.sv
// Sequences NUM_TESTS programs on a core under test, collecting tohost verdicts
// and guarding each run with a watchdog.
module rv32i_test_sequencer
    import rv32i_test_sequencer_pkg::*;
#(
    parameter int unsigned NUM_TESTS      = 4,
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_DEFAULT,
    parameter int unsigned RST_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int SEL_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    localparam int CNT_W = $clog2(NUM_TESTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    rv32i_test_sequencer_if.slave dmem,
    output logic                  core_rst,
    output logic [SEL_W-1:0]      test_sel,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  result_pass,
    output logic [30:0]           result_code,
    output logic [CNT_W-1:0]      pass_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  done,
    output logic                  all_pass
);

    localparam int RCNT_W = $clog2(RST_CYCLES + 1);

    seq_state_t        state, state_d;
    logic [RCNT_W-1:0] rst_cnt, rst_cnt_d;
    hit_t              hit;
    logic              wd_expired;
    logic              last_test;

    logic              core_rst_d, busy_d, result_valid_d, result_pass_d;
    logic              done_d, all_pass_d;
    logic [SEL_W-1:0]  test_sel_d;
    logic [30:0]       result_code_d;
    logic [CNT_W-1:0]  pass_cnt_d, fail_cnt_d;

    assign hit = classify_store(dmem.dmem_we, dmem.dmem_addr, dmem.dmem_be,
                                dmem.dmem_wdata, TOHOST_ADDR);
    assign last_test = (test_sel == SEL_W'(NUM_TESTS - 1));

    rv32i_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == SEQ_RESET_CORE),
        .en      (state == SEQ_RUN),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEQ_IDLE;
            rst_cnt      <= '0;
            core_rst     <= 1'b1;
            test_sel     <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_pass  <= 1'b0;
            result_code  <= '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            done         <= 1'b0;
            all_pass     <= 1'b0;
        end else begin
            state        <= state_d;
            rst_cnt      <= rst_cnt_d;
            core_rst     <= core_rst_d;
            test_sel     <= test_sel_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
            result_pass  <= result_pass_d;
            result_code  <= result_code_d;
            pass_cnt     <= pass_cnt_d;
            fail_cnt     <= fail_cnt_d;
            done         <= done_d;
            all_pass     <= all_pass_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d = state;
        case (state)
            SEQ_IDLE, SEQ_DONE: if (start) state_d = SEQ_RESET_CORE;
            SEQ_RESET_CORE:     if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) state_d = SEQ_RUN;
            SEQ_RUN:            if (hit != HIT_NONE || wd_expired) state_d = SEQ_RESULT;
            SEQ_RESULT:         state_d = last_test ? SEQ_DONE : SEQ_RESET_CORE;
            default:            state_d = SEQ_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned
    // with the state they describe.
    always_comb begin
        core_rst_d     = (state_d != SEQ_RUN);
        busy_d         = (state_d inside {SEQ_RESET_CORE, SEQ_RUN, SEQ_RESULT});
        result_valid_d = (state_d == SEQ_RESULT);
        done_d         = (state_d == SEQ_DONE);
        rst_cnt_d      = (state == SEQ_RESET_CORE && state_d == SEQ_RESET_CORE)
                         ? rst_cnt + RCNT_W'(1) : '0;
        test_sel_d     = test_sel;
        result_pass_d  = result_pass;
        result_code_d  = result_code;
        pass_cnt_d     = pass_cnt;
        fail_cnt_d     = fail_cnt;

        case (state)
            SEQ_IDLE, SEQ_DONE: begin
                if (start) begin
                    test_sel_d = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                end
            end
            SEQ_RUN: begin
                // A verdict store in the expiry cycle takes precedence.
                if (hit == HIT_PASS) begin
                    result_pass_d = 1'b1;
                    result_code_d = '0;
                end else if (hit == HIT_FAIL) begin
                    result_pass_d = 1'b0;
                    result_code_d = dmem.dmem_wdata[31:1];
                end else if (wd_expired) begin
                    result_pass_d = 1'b0;
                    result_code_d = TIMEOUT_CODE;
                end
            end
            SEQ_RESULT: begin
                if (result_pass) pass_cnt_d = pass_cnt + CNT_W'(1);
                else             fail_cnt_d = fail_cnt + CNT_W'(1);
                if (!last_test)  test_sel_d = test_sel + SEL_W'(1);
            end
            default: ;
        endcase

        all_pass_d = done_d && (fail_cnt_d == '0);
    end

endmodule

// File: tb/tb_rv32i_test_sequencer.sv
// Scoreboard bench: stimulus pushes expected verdicts, a negedge monitor
// pops and compares them whenever result_valid is seen.
module tb_rv32i_test_sequencer;
    import rv32i_test_sequencer_pkg::*;

    localparam int unsigned NT      = 2;
    localparam int unsigned RSTC    = 8;
    localparam int unsigned TMO     = 50;
    localparam logic [31:0] TOHOST  = TOHOST_DEFAULT;

    typedef struct packed {
        logic        pass;
        logic [30:0] code;
        logic [0:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        core_rst, busy, result_valid, result_pass, done, all_pass;
    logic [0:0]  test_sel;
    logic [30:0] result_code;
    logic [1:0]  pass_cnt, fail_cnt;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   n;

    rv32i_test_sequencer_if dmem_bus ();

    rv32i_test_sequencer #(
        .NUM_TESTS      (NT),
        .TOHOST_ADDR    (TOHOST),
        .RST_CYCLES     (RSTC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dmem         (dmem_bus.slave),
        .core_rst     (core_rst),
        .test_sel     (test_sel),
        .busy         (busy),
        .result_valid (result_valid),
        .result_pass  (result_pass),
        .result_code  (result_code),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .done         (done),
        .all_pass     (all_pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic expect_result(input logic pass, input logic [30:0] code,
                                 input logic [0:0] sel);
        exp_t x;
        x.pass = pass;
        x.code = code;
        x.sel  = sel;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result_pass", 32'(result_pass), 32'(e.pass));
                check("result_code", 32'(result_code), 32'(e.code));
                check("result_sel",  32'(test_sel),    32'(e.sel));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] data);
        dmem_bus.dmem_we    = 1'b1;
        dmem_bus.dmem_addr  = addr;
        dmem_bus.dmem_be    = be;
        dmem_bus.dmem_wdata = data;
        tick();
        dmem_bus.dmem_we    = 1'b0;
        dmem_bus.dmem_addr  = '0;
        dmem_bus.dmem_be    = '0;
        dmem_bus.dmem_wdata = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int k = 0;
        while (core_rst !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
        check(name, 32'(core_rst), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        dmem_bus.dmem_we    = 1'b0;
        dmem_bus.dmem_addr  = '0;
        dmem_bus.dmem_be    = '0;
        dmem_bus.dmem_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_core_rst", 32'(core_rst),     32'd1);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_valid",    32'(result_valid), 32'd0);
        check("rst_sel",      32'(test_sel),     32'd0);
        check("rst_pass_cnt", 32'(pass_cnt),     32'd0);
        check("rst_fail_cnt", 32'(fail_cnt),     32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_all_pass", 32'(all_pass),     32'd0);

        // Two passing programs, with latency and core_rst width between them
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        wait_run("t1_run0");
        expect_result(1'b1, 31'd0, 1'b0);
        store(TOHOST, 4'hF, 32'd1);
        check("t1_latency_valid", 32'(result_valid), 32'd1);
        check("t1_core_rst_rise", 32'(core_rst),     32'd1);
        n = 0;
        tick();
        while (core_rst === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check("t6_core_rst_cycles", 32'(n), RSTC);
        check("t1_sel1",      32'(test_sel), 32'd1);
        check("t1_pass_cnt1", 32'(pass_cnt), 32'd1);
        expect_result(1'b1, 31'd0, 1'b1);
        store(TOHOST, 4'hF, 32'd1);
        wait_done("t1_done");
        check("t1_pass_cnt", 32'(pass_cnt), 32'd2);
        check("t1_fail_cnt", 32'(fail_cnt), 32'd0);
        check("t1_all_pass", 32'(all_pass), 32'd1);
        check("t1_busy_off", 32'(busy),     32'd0);

        // Restart from DONE; one failing program
        pulse_start();
        check("t6_restart_pass_cnt", 32'(pass_cnt), 32'd0);
        check("t6_restart_done",     32'(done),     32'd0);
        check("t6_restart_sel",      32'(test_sel), 32'd0);
        wait_run("t2_run0");
        expect_result(1'b0, 31'd3, 1'b0);
        store(TOHOST, 4'hF, 32'h7);
        wait_run("t2_run1");
        expect_result(1'b1, 31'd0, 1'b1);
        store(TOHOST, 4'hF, 32'd1);
        wait_done("t2_done");
        check("t2_pass_cnt", 32'(pass_cnt), 32'd1);
        check("t2_fail_cnt", 32'(fail_cnt), 32'd1);
        check("t2_all_pass", 32'(all_pass), 32'd0);

        // Timeout, then a pass store landing in the expiry cycle
        pulse_start();
        wait_run("t3_run0");
        expect_result(1'b0, TIMEOUT_CODE, 1'b0);
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t3_timeout_latency", 32'(n), TMO);
        wait_run("t3_run1");
        repeat (TMO - 1) tick();
        check("t3_still_running", 32'(core_rst), 32'd0);
        expect_result(1'b1, 31'd0, 1'b1);
        store(TOHOST, 4'hF, 32'd1);
        check("t3_hit_wins_valid", 32'(result_valid), 32'd1);
        wait_done("t3_done");
        check("t3_pass_cnt", 32'(pass_cnt), 32'd1);
        check("t3_fail_cnt", 32'(fail_cnt), 32'd1);

        // Ignored stores: even data, partial byte enables, wrong address, outside RUN
        pulse_start();
        wait_run("t4_run0");
        store(TOHOST,          4'hF, 32'd2);
        store(TOHOST,          4'h3, 32'd1);
        store(TOHOST + 32'd4,  4'hF, 32'd1);
        check("t4_ignored_valid", 32'(result_valid), 32'd0);
        check("t4_ignored_run",   32'(core_rst),     32'd0);
        expect_result(1'b1, 31'd0, 1'b0);
        store(TOHOST, 4'hF, 32'd1);
        store(TOHOST, 4'hF, 32'd3);
        wait_run("t4_run1");
        expect_result(1'b0, 31'h7F, 1'b1);
        store(TOHOST, 4'hF, 32'hFF);
        wait_done("t4_done");
        check("t4_pass_cnt", 32'(pass_cnt), 32'd1);
        check("t4_fail_cnt", 32'(fail_cnt), 32'd1);

        // Start ignored while busy; rst aborts mid-RUN
        pulse_start();
        wait_run("t5_run0");
        expect_result(1'b1, 31'd0, 1'b0);
        store(TOHOST, 4'hF, 32'd1);
        wait_run("t5_run1");
        check("t5_busy", 32'(busy), 32'd1);
        pulse_start();
        check("t5_start_ignored_sel", 32'(test_sel), 32'd1);
        check("t5_start_ignored_run", 32'(core_rst), 32'd0);
        check("t5_pass_cnt_before",   32'(pass_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_abort_core_rst", 32'(core_rst),     32'd1);
        check("t5_abort_busy",     32'(busy),         32'd0);
        check("t5_abort_pass_cnt", 32'(pass_cnt),     32'd0);
        check("t5_abort_fail_cnt", 32'(fail_cnt),     32'd0);
        check("t5_abort_sel",      32'(test_sel),     32'd0);
        check("t5_abort_valid",    32'(result_valid), 32'd0);
        repeat (TMO + 10) tick();
        check("t5_idle_core_rst", 32'(core_rst), 32'd1);
        check("t5_idle_done",     32'(done),     32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
